// File: rtl/alu_exec_stage.sv
// Execute stage: handshake in, ALU settle window, writeback, response out.
// Includes the 32-bit ripple ALU used by the stage.
module thirty_two_bit_alu (
  output logic        zero,
  output logic [31:0] sum,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op
);

  logic [31:0] bb;
  logic [31:0] add;
  logic [32:0] c;

  // ripple adder; op[2] negates b for subtract/compare
  always_comb begin
    bb   = op[2] ? ~b : b;
    c    = '0;
    c[0] = op[2];
    add  = '0;
    for (int i = 0; i < 32; i++) begin
      add[i]   = a[i] ^ bb[i] ^ c[i];
      c[i+1]   = (a[i] & bb[i]) | (c[i] & (a[i] ^ bb[i]));
    end
  end

  // result select by opcode
  always_comb begin
    sum = '0;
    unique case (op)
      3'b000: sum = a & b;
      3'b001: sum = a | b;
      3'b010,
      3'b100,
      3'b110: sum = add;
      3'b111: sum = {31'b0, add[31]};
      default: sum = '0;
    endcase
  end

  assign zero = ~|sum;

endmodule

module alu_exec_stage #(
  parameter int EXEC_CYCLES = 4,
  parameter int REG_ADDR_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [REG_ADDR_W-1:0] in_rs,
  input  logic [REG_ADDR_W-1:0] in_rt,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  ld_en,
  input  logic [REG_ADDR_W-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_result,
  output logic                  out_zero,
  output logic                  out_taken,
  output logic                  out_illegal,
  output logic [REG_ADDR_W-1:0] out_rd,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [31:0]           dbg_data
);

  localparam int DEPTH = 1 << REG_ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [2:0]            lat_op;
  logic [REG_ADDR_W-1:0] lat_rd;
  logic [31:0]           lat_a;
  logic [31:0]           lat_b;
  logic [31:0]           rf [DEPTH];

  logic [31:0] alu_sum;
  logic        alu_zero;
  logic        lat_ill;
  logic        lat_wr;
  logic        done;
  logic        wb;

  thirty_two_bit_alu u_alu (
    .zero (alu_zero),
    .sum  (alu_sum),
    .a    (lat_a),
    .b    (lat_b),
    .op   (lat_op)
  );

  assign lat_ill  = (lat_op == 3'b011) || (lat_op == 3'b101);
  assign lat_wr   = !lat_ill && (lat_op != 3'b100);
  assign done     = (state == EXEC) && (cnt == 4'd0);
  assign wb       = done && lat_wr && (lat_rd != '0);
  assign in_ready = (state == IDLE);
  assign dbg_data = rf[dbg_addr];

  // register file: external load, then writeback overrides on collision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        rf[i] <= '0;
    end else begin
      if (ld_en && (ld_addr != '0))
        rf[ld_addr] <= ld_data;
      if (wb)
        rf[lat_rd] <= alu_sum;
    end
  end

  // control FSM with registered response outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_op      <= '0;
      lat_rd      <= '0;
      lat_a       <= '0;
      lat_b       <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_taken   <= 1'b0;
      out_illegal <= 1'b0;
      out_rd      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            lat_op <= in_op;
            lat_rd <= in_rd;
            lat_a  <= rf[in_rs];
            lat_b  <= rf[in_rt];
            cnt    <= CNT_INIT;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            out_result  <= lat_ill ? '0 : alu_sum;
            out_zero    <= lat_ill ? 1'b0 : alu_zero;
            out_taken   <= (lat_op == 3'b100) && alu_zero;
            out_illegal <= lat_ill;
            out_rd      <= lat_rd;
            out_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized and directed bench for alu_exec_stage.
// Reference model: array register file plus arithmetic per opcode.
module tb_alu_exec_stage;

  localparam int EC = 4;

  logic        clk = 0;
  logic        reset_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [2:0]  in_op = 0;
  logic [2:0]  in_rs = 0;
  logic [2:0]  in_rt = 0;
  logic [2:0]  in_rd = 0;
  logic        ld_en = 0;
  logic [2:0]  ld_addr = 0;
  logic [31:0] ld_data = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_taken;
  logic        out_illegal;
  logic [2:0]  out_rd;
  logic [2:0]  dbg_addr = 0;
  logic [31:0] dbg_data;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_rf [8];

  always #5 clk = ~clk;

  alu_exec_stage #(.EXEC_CYCLES(EC), .REG_ADDR_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_taken(out_taken), .out_illegal(out_illegal),
    .out_rd(out_rd), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic is_ill(input logic [2:0] op);
    return op == 3'd3 || op == 3'd5;
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd4, 3'd6: return d;
      3'd7: return {31'b0, d[31]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_wr(input logic [2:0] op);
    return op == 3'd0 || op == 3'd1 || op == 3'd2 ||
           op == 3'd6 || op == 3'd7;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
  endtask

  task automatic load(input logic [2:0] a, input logic [31:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 0;
    if (a != 0) m_rf[a] = d;
  endtask

  task automatic read_rf(input logic [2:0] a, output logic [31:0] d);
    dbg_addr = a; #1;
    d = dbg_data;
  endtask

  // issue one instruction; lat counts edges from accept (inclusive)
  task automatic run_op(input logic [2:0] op, input logic [2:0] rs,
                        input logic [2:0] rt, input logic [2:0] rd,
                        output int lat);
    in_valid = 1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (ref_wr(op) && rd != 0)
      m_rf[rd] = ref_res(op, m_rf[rs], m_rf[rt]);
  endtask

  task automatic ack();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 0 ||
        out_zero !== 0 || out_taken !== 0 || out_illegal !== 0 ||
        out_rd !== 0) begin
      failures++;
      $display("FAIL reset_outs rdy=%b v=%b res=%h z=%b t=%b i=%b rd=%0d want rdy=1 rest 0",
               in_ready, out_valid, out_result, out_zero, out_taken,
               out_illegal, out_rd);
    end
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    model_reset();
    load(3'd0, 32'h1234);
    read_rf(3'd0, d);
    checks++;
    if (d !== 0) begin
      failures++;
      $display("FAIL r0_load got=%h want=0", d);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [31:0] d;
    load(3'd1, 32'd5);
    load(3'd2, 32'd3);
    out_ready = 0;
    run_op(3'd2, 3'd1, 3'd2, 3'd3, lat);
    checks++;
    if (lat != EC + 1) begin
      failures++;
      $display("FAIL add_latency got=%0d want=%0d", lat, EC + 1);
    end
    checks++;
    if (out_result !== 32'd8 || out_zero !== 0 || out_rd !== 3'd3) begin
      failures++;
      $display("FAIL add_result res=%h z=%b rd=%0d want 8 0 3",
               out_result, out_zero, out_rd);
    end
    ack();
    checks++;
    if (out_valid !== 0 || in_ready !== 1) begin
      failures++;
      $display("FAIL add_ack v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    read_rf(3'd3, d);
    checks++;
    if (d !== 32'd8) begin
      failures++;
      $display("FAIL add_wb got=%h want=8", d);
    end
  endtask

  task automatic test_alu_ops();
    logic [2:0]  ops [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    logic [2:0]  rss [4] = '{3'd2, 3'd2, 3'd1, 3'd1};
    logic [2:0]  rts [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
    logic [2:0]  rds [4] = '{3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] exp [4] = '{32'hFFFFFFFE, 32'd1, 32'd1, 32'd7};
    int lat;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], rss[i], rts[i], rds[i], lat);
      checks++;
      if (out_result !== exp[i] || out_zero !== (exp[i] == 0) ||
          out_taken !== 0 || out_illegal !== 0 || lat != EC + 1) begin
        failures++;
        $display("FAIL op%0d res=%h z=%b t=%b i=%b lat=%0d want res=%h",
                 ops[i], out_result, out_zero, out_taken, out_illegal,
                 lat, exp[i]);
      end
      ack();
      read_rf(rds[i], d);
      checks++;
      if (d !== exp[i]) begin
        failures++;
        $display("FAIL op%0d_wb got=%h want=%h", ops[i], d, exp[i]);
      end
    end
  endtask

  task automatic test_beq();
    int lat;
    logic [31:0] d;
    load(3'd6, 32'd5);
    m_rf[7] = 0;
    load(3'd7, 32'd0);
    run_op(3'd4, 3'd1, 3'd6, 3'd7, lat);
    checks++;
    if (out_taken !== 1 || out_zero !== 1 || out_result !== 0) begin
      failures++;
      $display("FAIL beq_eq t=%b z=%b res=%h want 1 1 0",
               out_taken, out_zero, out_result);
    end
    ack();
    read_rf(3'd7, d);
    checks++;
    if (d !== 0) begin
      failures++;
      $display("FAIL beq_nowb got=%h want=0", d);
    end
    run_op(3'd4, 3'd1, 3'd2, 3'd7, lat);
    checks++;
    if (out_taken !== 0 || out_zero !== 0 || out_result !== 32'd2) begin
      failures++;
      $display("FAIL beq_ne t=%b z=%b res=%h want 0 0 2",
               out_taken, out_zero, out_result);
    end
    ack();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(3'd2, 3'd1, 3'd2, 3'd3, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; in_op = 3'd0; in_rd = 3'd4;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1 || out_result !== 32'd8 || in_ready !== 0) begin
        failures++;
        $display("FAIL hold%0d v=%b res=%h rdy=%b want 1 8 0",
                 i, out_valid, out_result, in_ready);
      end
    end
    in_valid = 0;
    ack();
    checks++;
    if (out_valid !== 0 || in_ready !== 1) begin
      failures++;
      $display("FAIL hold_ack v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    repeat (EC + 3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 0 || in_ready !== 1) begin
      failures++;
      $display("FAIL hold_noaccept v=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_illegal();
    int lat;
    logic [31:0] d;
    run_op(3'd3, 3'd1, 3'd2, 3'd5, lat);
    checks++;
    if (out_illegal !== 1 || out_result !== 0 || out_zero !== 0 ||
        out_taken !== 0) begin
      failures++;
      $display("FAIL illegal i=%b res=%h z=%b t=%b want 1 0 0 0",
               out_illegal, out_result, out_zero, out_taken);
    end
    ack();
    for (int i = 0; i < 8; i++) begin
      read_rf(3'(i), d);
      checks++;
      if (d !== m_rf[i]) begin
        failures++;
        $display("FAIL illegal_rf r%0d got=%h want=%h", i, d, m_rf[i]);
      end
    end
    run_op(3'd2, 3'd1, 3'd2, 3'd0, lat);
    ack();
    read_rf(3'd0, d);
    checks++;
    if (d !== 0) begin
      failures++;
      $display("FAIL add_r0 got=%h want=0", d);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [2:0] op, rs, rt, rd;
    logic [31:0] a, b, er, d;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        load(3'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 3) == 0)
        load(3'($urandom_range(1, 7)), m_rf[$urandom_range(0, 7)]);
      op = 3'($urandom_range(0, 7));
      rs = 3'($urandom_range(0, 7));
      rt = 3'($urandom_range(0, 7));
      rd = 3'($urandom_range(0, 7));
      a = m_rf[rs];
      b = m_rf[rt];
      er = ref_res(op, a, b);
      run_op(op, rs, rt, rd, lat);
      checks++;
      if (lat != EC + 1 || out_result !== er ||
          out_zero !== (!is_ill(op) && er == 0) ||
          out_taken !== (op == 3'd4 && er == 0) ||
          out_illegal !== is_ill(op) || out_rd !== rd) begin
        failures++;
        $display("FAIL rand%0d op=%0d a=%h b=%h res=%h z=%b t=%b i=%b lat=%0d want res=%h",
                 n, op, a, b, out_result, out_zero, out_taken,
                 out_illegal, lat, er);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      ack();
      read_rf(rd, d);
      checks++;
      if (d !== m_rf[rd]) begin
        failures++;
        $display("FAIL rand%0d_wb r%0d got=%h want=%h", n, rd, d, m_rf[rd]);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [31:0] d;
    load(3'd1, 32'd5);
    load(3'd2, 32'd3);
    load(3'd3, 32'd77);
    in_valid = 1; in_op = 3'd2; in_rs = 3'd1; in_rt = 3'd2; in_rd = 3'd3;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    reset_n = 0;
    #1;
    read_rf(3'd3, d);
    checks++;
    if (out_valid !== 0 || out_result !== 0 || out_rd !== 0 ||
        in_ready !== 1 || d !== 0) begin
      failures++;
      $display("FAIL mid_reset v=%b res=%h rd=%0d rdy=%b r3=%h want 0 0 0 1 0",
               out_valid, out_result, out_rd, in_ready, d);
    end
    @(negedge clk); reset_n = 1;
    model_reset();
    repeat (EC + 3) @(posedge clk);
    #1;
    read_rf(3'd3, d);
    checks++;
    if (out_valid !== 0 || d !== 0) begin
      failures++;
      $display("FAIL mid_reset_after v=%b r3=%h want 0 0", out_valid, d);
    end
  endtask

  task automatic test_wb_collision();
    logic [31:0] d;
    load(3'd1, 32'd5);
    load(3'd2, 32'd3);
    in_valid = 1; in_op = 3'd2; in_rs = 3'd1; in_rt = 3'd2; in_rd = 3'd3;
    @(posedge clk); #1;
    in_valid = 0;
    for (int k = 1; k < EC; k++) begin
      @(posedge clk); #1;
    end
    ld_en = 1; ld_addr = 3'd3; ld_data = 32'hDEAD;
    @(posedge clk); #1;
    ld_en = 0;
    read_rf(3'd3, d);
    checks++;
    if (out_valid !== 1 || d !== 32'd8) begin
      failures++;
      $display("FAIL wb_collision v=%b r3=%h want 1 8", out_valid, d);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alu_ops();
    test_beq();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid_exec();
    test_wb_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
